// File: rtl/button_events.sv
// -----------------------------------------------------------------------------
// button_events
//   Turns debounced press/release pulses into gesture events: single click,
//   double click, long press, and auto-repeat while a long press is held.
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   asynchronous active-high reset
//   button_down   in   one-cycle pulse, debounced press
//   button_up     in   one-cycle pulse, debounced release
//   click         out  registered pulse: single short press confirmed
//   double_click  out  registered pulse: second press inside the gap window
//   long_press    out  registered pulse: press held LONG_CYCLES
//   repeat_pulse  out  registered pulse every REPEAT_CYCLES after long_press
//                      (the plain name "repeat" is a SystemVerilog keyword)
//   busy          out  high whenever a gesture is in progress (state != IDLE)
// -----------------------------------------------------------------------------
module button_events #(
  parameter int unsigned LONG_CYCLES   = 12_000_000,
  parameter int unsigned GAP_CYCLES    = 3_000_000,
  parameter int unsigned REPEAT_CYCLES = 2_400_000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic button_down,
  input  logic button_up,
  output logic click,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } state_t;

  // Last timer value before each phase expires.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             down_ev;
  logic             up_ev;

  // Both edges in the same cycle cancel out and count as no event.
  assign down_ev = button_down & ~button_up;
  assign up_ev   = button_up & ~button_down;

  assign busy = (state != IDLE);

  // Button edges are tested before timer expiry so an edge landing on the
  // expiry cycle always wins. Pulses default low, so each lasts one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (down_ev) state <= PRESS1;
        end
        PRESS1: begin
          if (up_ev) begin
            state <= WAIT2;
            timer <= '0;
          end else if (timer == LONG_LAST) begin
            state      <= HELD;
            timer      <= '0;
            long_press <= 1'b1;
          end else begin
            timer <= timer + ONE;
          end
        end
        WAIT2: begin
          if (down_ev) begin
            state        <= PRESS2;
            timer        <= '0;
            double_click <= 1'b1;
          end else if (timer == GAP_LAST) begin
            state <= IDLE;
            timer <= '0;
            click <= 1'b1;
          end else begin
            timer <= timer + ONE;
          end
        end
        PRESS2: begin
          // Second press of a double click: nothing more to report.
          timer <= '0;
          if (up_ev) state <= IDLE;
        end
        HELD: begin
          if (up_ev) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == RPT_LAST) begin
            timer        <= '0;
            repeat_pulse <= 1'b1;
          end else begin
            timer <= timer + ONE;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_events.sv
// -----------------------------------------------------------------------------
// tb_button_events
//   Self-checking bench for button_events with short timing parameters
//   (LONG=8, GAP=4, REPEAT=3). Table-driven vectors for the documented
//   gestures, hand-written long-press and reset sequences, then random
//   stimulus compared against a timestamp-based gesture model.
// -----------------------------------------------------------------------------
module tb_button_events;

  localparam int LONG   = 8;
  localparam int GAP    = 4;
  localparam int REPEAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button_down = 1'b0;
  logic button_up = 1'b0;
  logic click, double_click, long_press, repeat_pulse, busy;

  int nvec = 0;
  int nerr = 0;

  button_events #(
    .LONG_CYCLES  (LONG),
    .GAP_CYCLES   (GAP),
    .REPEAT_CYCLES(REPEAT),
    .CNT_W        (24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .button_down (button_down),
    .button_up   (button_up),
    .click       (click),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_pulse(repeat_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Output vector layout: {click, double_click, long_press, repeat, busy}
  typedef struct {
    bit         d;
    bit         u;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  // ---------------- reference model ----------------
  // Gesture phase plus the cycle stamp at which it was entered; expiries are
  // judged from elapsed cycles since that stamp.
  // phase: 0 none, 1 first press, 2 release gap, 3 second press, 4 held
  int     m_phase;
  longint m_now;
  longint m_mark;
  bit     e_click, e_dbl, e_long, e_rpt;

  function automatic void model_reset();
    m_phase = 0;
    m_now   = 0;
    m_mark  = 0;
    e_click = 0; e_dbl = 0; e_long = 0; e_rpt = 0;
  endfunction

  function automatic void model_step(bit d, bit u);
    bit press, release_;
    longint el;
    press    = d && !u;
    release_ = u && !d;
    m_now++;
    el = m_now - m_mark;
    e_click = 0; e_dbl = 0; e_long = 0; e_rpt = 0;
    case (m_phase)
      0: if (press) begin m_phase = 1; m_mark = m_now; end
      1: if (release_) begin m_phase = 2; m_mark = m_now; end
         else if (el == LONG) begin m_phase = 4; m_mark = m_now; e_long = 1; end
      2: if (press) begin m_phase = 3; m_mark = m_now; e_dbl = 1; end
         else if (el == GAP) begin m_phase = 0; e_click = 1; end
      3: if (release_) m_phase = 0;
      default: if (release_) m_phase = 0;
               else if (el % REPEAT == 0) e_rpt = 1;
    endcase
  endfunction

  function automatic logic [4:0] model_out();
    return {e_click, e_dbl, e_long, e_rpt, (m_phase != 0)};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {click, double_click, long_press, repeat_pulse, busy};
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s #%0d: got %b want %b (click,dbl,long,rpt,busy)",
               name, nvec, act, exp);
    end else begin
      $display("vec %0d %s: d=%b u=%b out=%b ok", nvec, name,
               button_down, button_up, act);
    end
  endtask

  // One clock: drive inputs, step the model on the edge, sample 1 ns later.
  task automatic cycle(input bit d, input bit u);
    button_down = d;
    button_up   = u;
    @(posedge clk);
    model_step(d, u);
    #1;
  endtask

  initial begin
    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 5'b00000);
    model_reset();
    rst = 1'b0;

    // ---- table: single click (down t, up t+3 -> click at t+8) ----
    tbl.push_back('{1, 0, 5'b00001});
    tbl.push_back('{0, 0, 5'b00001});
    tbl.push_back('{0, 0, 5'b00001});
    tbl.push_back('{0, 1, 5'b00001});
    for (int i = 0; i < 3; i++) tbl.push_back('{0, 0, 5'b00001});
    tbl.push_back('{0, 0, 5'b10000});
    tbl.push_back('{0, 0, 5'b00000});
    // ---- table: double click (down t, up t+2, down t+4, up t+6) ----
    tbl.push_back('{1, 0, 5'b00001});
    tbl.push_back('{0, 0, 5'b00001});
    tbl.push_back('{0, 1, 5'b00001});
    tbl.push_back('{0, 0, 5'b00001});
    tbl.push_back('{1, 0, 5'b01001});
    tbl.push_back('{0, 0, 5'b00001});
    tbl.push_back('{0, 1, 5'b00000});
    for (int i = 0; i < 5; i++) tbl.push_back('{0, 0, 5'b00000});
    // ---- table: both edges at once in IDLE -> nothing ----
    tbl.push_back('{1, 1, 5'b00000});
    tbl.push_back('{0, 0, 5'b00000});
    tbl.push_back('{0, 1, 5'b00000});
    // ---- table: release on the last PRESS1 cycle -> no long, click t+13 ----
    tbl.push_back('{1, 0, 5'b00001});
    for (int i = 0; i < 7; i++) tbl.push_back('{0, 0, 5'b00001});
    tbl.push_back('{0, 1, 5'b00001});
    for (int i = 0; i < 3; i++) tbl.push_back('{0, 0, 5'b00001});
    tbl.push_back('{0, 0, 5'b10000});
    tbl.push_back('{0, 0, 5'b00000});
    // ---- table: press during PRESS2 ignored, release on gap expiry ----
    tbl.push_back('{1, 0, 5'b00001});
    tbl.push_back('{0, 1, 5'b00001});
    for (int i = 0; i < 3; i++) tbl.push_back('{0, 0, 5'b00001});
    tbl.push_back('{1, 0, 5'b01001});  // down on the last gap cycle wins
    tbl.push_back('{1, 0, 5'b00001});
    for (int i = 0; i < 12; i++) tbl.push_back('{0, 0, 5'b00001});
    tbl.push_back('{0, 1, 5'b00000});
    tbl.push_back('{0, 0, 5'b00000});

    foreach (tbl[i]) begin
      cycle(tbl[i].d, tbl[i].u);
      check("table", tbl[i].exp);
    end

    // ---- long press with repeats, release on a repeat expiry ----
    for (int k = 0; k <= 22; k++) begin
      logic [4:0] e;
      e = {1'b0, 1'b0, (k == 8), (k == 11 || k == 14 || k == 17), (k <= 19)};
      cycle(k == 0, k == 20);
      check("long_repeat", e);
    end

    // ---- reset in the middle of a held press ----
    for (int k = 0; k < 10; k++) begin
      cycle(k == 0, 0);
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 5'b00000);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_held", 5'b00000);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle(0, 0);
      check("post_rst_quiet", 5'b00000);
    end
    // fresh click after reset
    for (int k = 0; k < 9; k++) begin
      logic [4:0] e;
      e = (k == 7) ? 5'b10000 : (k == 8) ? 5'b00000 : 5'b00001;
      cycle(k == 0, k == 3);
      check("post_rst_click", e);
    end

    // ---- random stimulus vs. model ----
    for (int i = 0; i < 2500; i++) begin
      int r;
      bit d, u;
      r = int'($urandom_range(0, 99));
      d = (r < 12) || (r >= 97);
      u = (r >= 12 && r < 24) || (r >= 97);
      cycle(d, u);
      check("random", model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 Parameter LONG_CYCLES, default 12_000_000: press duration, in cycles, that classifies a press as long.
REQ-002 Parameter GAP_CYCLES, default 3_000_000: maximum release-to-press gap, in cycles, for a double click.
REQ-003 Parameter REPEAT_CYCLES, default 2_400_000: auto-repeat period, in cycles, while a long press is held.
REQ-004 Parameter CNT_W, default 24: timer width; all three cycle parameters SHALL be >= 2 and < 2^CNT_W.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 button_down  input  1  one-cycle pulse, debounced press, synchronous to clk.
REQ-008 button_up  input  1  one-cycle pulse, debounced release, synchronous to clk.
REQ-009 click  output  1  registered one-cycle pulse, single short press confirmed.
REQ-010 double_click  output  1  registered one-cycle pulse, second press within the gap window.
REQ-011 long_press  output  1  registered one-cycle pulse, press held LONG_CYCLES.
REQ-012 repeat  output  1  registered one-cycle pulse, every REPEAT_CYCLES while held after long_press.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, PRESS1, WAIT2, PRESS2 and HELD, plus one CNT_W-bit timer that is cleared on every state transition.
REQ-015 IDLE: button_down -> PRESS1; all other inputs ignored.
REQ-016 PRESS1: timer increments each cycle; button_up -> WAIT2; timer == LONG_CYCLES-1 with no button_up -> HELD, long_press high next cycle.
REQ-017 WAIT2: timer increments; button_down -> PRESS2, double_click high next cycle; timer == GAP_CYCLES-1 with no button_down -> IDLE, click high next cycle.
REQ-018 PRESS2: button_up -> IDLE; no other event is generated, even if the press is held indefinitely.
REQ-019 HELD: timer increments; timer == REPEAT_CYCLES-1 -> repeat high next cycle, timer wraps to 0, state unchanged; button_up -> IDLE with no pulse.
REQ-020 Simultaneous events: a button edge on the same cycle as timer expiry SHALL win. In PRESS1, button_up at timer == LONG_CYCLES-1 -> WAIT2, no long_press. In WAIT2, button_down at timer == GAP_CYCLES-1 -> double_click, no click. In HELD, button_up at the repeat expiry -> IDLE, no repeat.
REQ-021 button_down and button_up high in the same cycle SHALL be treated as no event in every state.
REQ-022 A button_up in IDLE or WAIT2, and a button_down in PRESS1, PRESS2 or HELD, SHALL be ignored.
REQ-023 At most one of click, double_click, long_press and repeat SHALL be high in any cycle, and each pulse SHALL last exactly one cycle.
REQ-024 The timer SHALL never exceed its state's limit minus one; no overflow or wrap-around is permitted beyond REQ-019.
REQ-025 busy SHALL be a decode of the state register: 1 in PRESS1, WAIT2, PRESS2 and HELD, 0 in IDLE.

Reset
REQ-026 While rst is high, asynchronously: state=IDLE, timer=0, click=0, double_click=0, long_press=0, repeat=0, busy=0.
REQ-027 Reset asserted mid-operation (any state) SHALL abort the gesture with no pulse after release; the first cycle after deassertion SHALL be IDLE.
REQ-028 No button_down that coincides with reset deassertion SHALL be required to register.

Verification (LONG_CYCLES=8, GAP_CYCLES=4, REPEAT_CYCLES=3; t = cycle of the first button_down)
REQ-029 Single click: down at t, up at t+3 -> click high only at t+8; busy low from t+8.
REQ-030 Double click: down t, up t+2, down t+4, up t+6 -> double_click high only at t+5; no click; busy low at t+7.
REQ-031 Long and repeat: down at t, held to t+20 -> long_press at t+9; repeat at t+12, t+15 and t+18; up at t+20 -> IDLE at t+21, no further pulses.
REQ-032 Boundary: down t, up t+8 (timer == 7) -> no long_press; click at t+13.
REQ-033 Reset: rst pulsed at t+10 of REQ-031 -> all outputs 0 in the same cycle; no repeat pulses after release; a fresh down/up sequence then behaves as in REQ-029.
REQ-034 Illegal input: button_down and button_up both high for one cycle in IDLE -> busy stays 0 and no pulses are produced.
